// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: data width, reset/NOP defaults and the
// fetch-stage state encoding.
package rv_pkg;
  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] INST_BYTES       = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: flush (NOP, invalid) beats load, otherwise hold.
module if_id_reg
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o
);

  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      inst_q  <= NOP_INST;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      inst_q  <= inst_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/inst_fetch.sv
// RV32I instruction-fetch stage: PC, I-cache request handshake, one-entry
// skid buffer for decode back-pressure, and the IF/ID register.
module inst_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  output logic            icache_ren,
  output logic [XLEN-1:0] icache_addr,
  input  logic [XLEN-1:0] icache_rdata,
  input  logic            icache_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic [XLEN-1:0] if_id_inst,
  output logic [XLEN-1:0] if_id_pc,
  output logic            if_id_valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_q, req_d;
  logic [XLEN-1:0] buf_inst_q, buf_inst_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;

  logic            ren;
  logic            accept;
  logic            ifid_load;
  logic            ifid_flush;
  logic [XLEN-1:0] ifid_inst;
  logic [XLEN-1:0] ifid_pc;

  assign icache_ren  = ren & ~rst;
  assign icache_addr = req_q;
  assign accept      = icache_ren & ~icache_stall;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    ren        = 1'b0;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_inst  = icache_rdata;
    ifid_pc    = req_q;

    unique case (state_q)
      FETCH: begin
        ren = 1'b1;
        if (redirect_valid) begin
          ifid_flush = 1'b1;
          pc_d       = redirect_pc;
          // A stalled request cannot be withdrawn; drain it before retargeting.
          if (accept) req_d   = redirect_pc;
          else        state_d = DRAIN;
        end else if (accept) begin
          pc_d  = req_q + INST_BYTES;
          req_d = req_q + INST_BYTES;
          if (id_stall) begin
            buf_inst_d = icache_rdata;
            buf_pc_d   = req_q;
            state_d    = HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end else if (!id_stall) begin
          ifid_flush = 1'b1;
        end
      end

      HOLD: begin
        ifid_inst = buf_inst_q;
        ifid_pc   = buf_pc_q;
        if (redirect_valid) begin
          ifid_flush = 1'b1;
          pc_d       = redirect_pc;
          req_d      = redirect_pc;
          state_d    = FETCH;
        end else if (!id_stall) begin
          ifid_load = 1'b1;
          state_d   = FETCH;
        end
      end

      DRAIN: begin
        ren        = 1'b1;
        ifid_flush = 1'b1;
        if (redirect_valid) pc_d = redirect_pc;
        if (accept) begin
          req_d   = pc_d;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_q      <= RESET_PC;
      buf_inst_q <= NOP_INST;
      buf_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .inst_i  (ifid_inst),
    .pc_i    (ifid_pc),
    .inst_o  (if_id_inst),
    .pc_o    (if_id_pc),
    .valid_o (if_id_valid)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: per-cycle vector table plus hand-written
// reset-mid-request and PC-wrap sequences.
module tb_inst_fetch;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] MEM_KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren, stall, rd_valid, ids, v;
  logic [31:0] addr, rdata, rpc, inst, pc;

  logic        ren2, v2;
  logic [31:0] addr2, rdata2, inst2, pc2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Cache model: the word at an address is a fixed scramble of that address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ MEM_KEY;
  endfunction

  assign rdata  = mem_word(addr);
  assign rdata2 = mem_word(addr2);

  inst_fetch dut (
    .clk(clk), .rst(rst), .icache_ren(ren), .icache_addr(addr),
    .icache_rdata(rdata), .icache_stall(stall), .redirect_valid(rd_valid),
    .redirect_pc(rpc), .id_stall(ids), .if_id_inst(inst), .if_id_pc(pc),
    .if_id_valid(v)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .icache_ren(ren2), .icache_addr(addr2),
    .icache_rdata(rdata2), .icache_stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .id_stall(1'b0), .if_id_inst(inst2), .if_id_pc(pc2),
    .if_id_valid(v2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        ids;
    logic        ren;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] r,
                              input logic is, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t t;
    t.st = st; t.rd = rd; t.rpc = r; t.ids = is;
    t.ren = er; t.addr = ea; t.v = ev; t.pc = ep;
    return t;
  endfunction

  vec_t tbl [30];

  initial begin
    //            st  rd  rpc        ids ren addr       v   pc
    tbl[0]  = mk(0, 0, 32'h0,   0, 1, 32'h000, 1, 32'h000);
    tbl[1]  = mk(0, 0, 32'h0,   0, 1, 32'h004, 1, 32'h004);
    tbl[2]  = mk(1, 0, 32'h0,   0, 1, 32'h008, 0, 32'h000);
    tbl[3]  = mk(1, 0, 32'h0,   0, 1, 32'h008, 0, 32'h000);
    tbl[4]  = mk(1, 0, 32'h0,   0, 1, 32'h008, 0, 32'h000);
    tbl[5]  = mk(0, 0, 32'h0,   0, 1, 32'h008, 1, 32'h008);
    tbl[6]  = mk(0, 0, 32'h0,   1, 1, 32'h00C, 1, 32'h008);
    tbl[7]  = mk(0, 0, 32'h0,   1, 0, 32'h010, 1, 32'h008);
    tbl[8]  = mk(0, 0, 32'h0,   0, 0, 32'h010, 1, 32'h00C);
    tbl[9]  = mk(0, 0, 32'h0,   0, 1, 32'h010, 1, 32'h010);
    tbl[10] = mk(0, 0, 32'h0,   0, 1, 32'h014, 1, 32'h014);
    tbl[11] = mk(0, 0, 32'h0,   0, 1, 32'h018, 1, 32'h018);
    tbl[12] = mk(0, 0, 32'h0,   0, 1, 32'h01C, 1, 32'h01C);
    tbl[13] = mk(1, 1, 32'h100, 0, 1, 32'h020, 0, 32'h000);
    tbl[14] = mk(1, 0, 32'h0,   0, 1, 32'h020, 0, 32'h000);
    tbl[15] = mk(0, 0, 32'h0,   0, 1, 32'h020, 0, 32'h000);
    tbl[16] = mk(0, 0, 32'h0,   0, 1, 32'h100, 1, 32'h100);
    tbl[17] = mk(0, 0, 32'h0,   1, 1, 32'h104, 1, 32'h100);
    tbl[18] = mk(0, 1, 32'h40,  1, 0, 32'h108, 0, 32'h000);
    tbl[19] = mk(0, 0, 32'h0,   0, 1, 32'h040, 1, 32'h040);
    tbl[20] = mk(0, 0, 32'h0,   1, 1, 32'h044, 1, 32'h040);
    tbl[21] = mk(0, 0, 32'h0,   1, 0, 32'h048, 1, 32'h040);
    tbl[22] = mk(0, 0, 32'h0,   0, 0, 32'h048, 1, 32'h044);
    tbl[23] = mk(0, 1, 32'h200, 0, 1, 32'h048, 0, 32'h000);
    tbl[24] = mk(0, 0, 32'h0,   0, 1, 32'h200, 1, 32'h200);
    tbl[25] = mk(1, 0, 32'h0,   1, 1, 32'h204, 1, 32'h200);
    tbl[26] = mk(0, 0, 32'h0,   0, 1, 32'h204, 1, 32'h204);
    tbl[27] = mk(1, 1, 32'h300, 0, 1, 32'h208, 0, 32'h000);
    tbl[28] = mk(0, 1, 32'h400, 0, 1, 32'h208, 0, 32'h000);
    tbl[29] = mk(0, 0, 32'h0,   0, 1, 32'h400, 1, 32'h400);

    rst = 1'b1; stall = 1'b0; rd_valid = 1'b0; rpc = '0; ids = 1'b0;
    @(posedge clk); #1;
    check("ren_during_rst", {31'b0, ren}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_valid", {31'b0, v}, 32'd0);
    check("reset_inst", inst, NOP);
    check("reset_pc", pc, 32'h0);

    for (int i = 0; i < 30; i++) begin
      stall = tbl[i].st; rd_valid = tbl[i].rd; rpc = tbl[i].rpc; ids = tbl[i].ids;
      #1;
      check($sformatf("v%0d_ren", i), {31'b0, ren}, {31'b0, tbl[i].ren});
      check($sformatf("v%0d_addr", i), addr, tbl[i].addr);
      @(posedge clk); #1;
      check($sformatf("v%0d_valid", i), {31'b0, v}, {31'b0, tbl[i].v});
      check($sformatf("v%0d_pc", i), pc, tbl[i].pc);
      check($sformatf("v%0d_inst", i), inst, tbl[i].v ? mem_word(tbl[i].pc) : NOP);
      @(negedge clk);
    end

    // Reset while a request is stalled: request abandoned, PCs restart.
    stall = 1'b1; rd_valid = 1'b0; rpc = '0; ids = 1'b0;
    #1;
    check("pre_rst_addr", addr, 32'h404);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_req_ren", {31'b0, ren}, 32'd0);
    check("rst_wrap_ren", {31'b0, ren2}, 32'd0);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    #1;
    check("post_rst_addr", addr, 32'h0);
    check("post_rst_ren", {31'b0, ren}, 32'd1);
    check("post_rst_valid", {31'b0, v}, 32'd0);
    check("wrap_addr0", addr2, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("wrap_ifid_pc0", pc2, 32'hFFFF_FFF8);
    check("wrap_ifid_inst0", inst2, mem_word(32'hFFFF_FFF8));
    @(negedge clk); #1;
    check("wrap_addr1", addr2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap_ifid_pc1", pc2, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("wrap_addr2", addr2, 32'h0000_0000);
    @(posedge clk); #1;
    check("wrap_ifid_pc2", pc2, 32'h0000_0000);
    check("wrap_valid", {31'b0, v2}, 32'd1);
    check("post_rst_ifid_pc", pc, 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
